// File: rtl/alu_result_stage.sv
// Registered ALU result stage: six-op WIDTH-bit ALU feeding a two-entry valid/ready buffer.
// Optional N/Z/C/V flag storage is built only when ALU_FLAGS_EN is defined.
//
//   state    | meaning
//   ---------+--------------------------------------------
//   ST_EMPTY | OUT invalid, SKID invalid
//   ST_ONE   | OUT valid, SKID invalid
//   ST_FULL  | OUT valid, SKID valid (in_ready low)
module alu_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [3:0]       out_flags
);

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             drain;
  logic             skid_valid;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  logic [WIDTH-1:0] new_data;
  logic             new_err;

  logic [WIDTH-1:0] out_data_q;
  logic             out_err_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_err_q;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
`else
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] diff_w;
  assign sum_w  = a + b;
  assign diff_w = a - b;
`endif

  always_comb begin
    new_data = '0;
    new_err  = 1'b0;
    unique case (aop)
      OP_MOV:  new_data = a;
      OP_NOT:  new_data = ~a;
      OP_NAND: new_data = ~(a & b);
      OP_NOR:  new_data = ~(a | b);
      OP_SUB:  new_data = diff_w[WIDTH-1:0];
      OP_ADD:  new_data = sum_w[WIDTH-1:0];
      default: new_err  = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] new_flags;
  logic [3:0] out_flags_q;
  logic [3:0] skid_flags_q;
  logic       flag_c;
  logic       flag_v;

  // Carry for sub is "no borrow", i.e. the inverted top bit of the widened difference.
  always_comb begin
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (aop == OP_ADD) begin
      flag_c = sum_w[WIDTH];
      flag_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    end else if (aop == OP_SUB) begin
      flag_c = ~diff_w[WIDTH];
      flag_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
    end
    new_flags = {new_data[WIDTH-1], (new_data == '0), flag_c, flag_v};
  end
`endif

  // ---------------------------------------------------------------------------
  // Buffer control
  // ---------------------------------------------------------------------------
  assign out_valid  = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);
  assign in_ready   = !rst && !skid_valid;
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_out_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_nxt     = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      if (load_out_new) begin
        out_data_q <= new_data;
        out_err_q  <= new_err;
      end else if (load_out_skid) begin
        out_data_q <= skid_data_q;
        out_err_q  <= skid_err_q;
      end
      if (load_skid) begin
        skid_data_q <= new_data;
        skid_err_q  <= new_err;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flags_q  <= 4'b0000;
      skid_flags_q <= 4'b0000;
    end else begin
      if (load_out_new) begin
        out_flags_q <= new_flags;
      end else if (load_out_skid) begin
        out_flags_q <= skid_flags_q;
      end
      if (load_skid) begin
        skid_flags_q <= new_flags;
      end
    end
  end

  assign out_flags = out_flags_q;
`else
  assign out_flags = 4'b0000;
`endif

  assign out_data = out_data_q;
  assign out_err  = out_err_q;

endmodule
